connect4_board: RTL

Game-state engine for the Connect Four display path. Accepts column-drop requests from the input/controller logic, drops the current player's piece into the lowest empty row of that column, and checks for a four-in-a-row win with a small sequential scan. Maintains the 6×7 `grid` array that the VGA renderer reads directly. It also reports whose turn it is, game-over, and winner status.

---
 rtl/connect4_pkg.sv | 34 +++
 rtl/c4_line_count.sv | 51 +++++
 rtl/connect4_board.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect Four types: board geometry, cell/winner encodings, engine FSM states.
// Pure definitions; no timing or flow control.
package connect4_pkg;
    localparam int ROWS    = 6;
    localparam int COLS    = 7;
    localparam int WIN_LEN = 4;
    localparam int CELLS   = ROWS * COLS;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    // Row 0 is the top row, column 0 the left column, as the renderer scans it.
    typedef logic [0:ROWS-1][0:COLS-1][1:0] board_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLACE,
        S_CHK_H,
        S_CHK_V,
        S_CHK_D1,
        S_CHK_D2,
        S_END
    } state_t;
endpackage

// File: rtl/c4_line_count.sv
// Counts contiguous player cells through (row,col) along +/-(dr,dc), saturating at WIN_LEN.
// Purely combinational, no flow control.
module c4_line_count
    import connect4_pkg::*;
(
    input  board_t            board_i,
    input  logic [2:0]        row_i,
    input  logic [2:0]        col_i,
    input  logic signed [1:0] dr_i,
    input  logic signed [1:0] dc_i,
    input  logic [1:0]        player_i,
    output logic [2:0]        count_o
);
    localparam logic signed [4:0] ROW_LIM = 5'(ROWS);
    localparam logic signed [4:0] COL_LIM = 5'(COLS);

    logic signed [4:0] r, c, dr, dc;
    logic              run;
    logic [2:0]        cnt;

    always_comb begin
        dr  = {{3{dr_i[1]}}, dr_i};
        dc  = {{3{dc_i[1]}}, dc_i};
        cnt = 3'd1;
        r   = '0;
        c   = '0;
        run = 1'b0;
        // side 0 walks forward along the direction, side 1 walks backward
        for (int side = 0; side < 2; side++) begin
            r   = $signed({2'b00, row_i});
            c   = $signed({2'b00, col_i});
            run = 1'b1;
            for (int k = 1; k < WIN_LEN; k++) begin
                if (side == 0) begin
                    r = r + dr;
                    c = c + dc;
                end else begin
                    r = r - dr;
                    c = c - dc;
                end
                if (run && (r >= 5'sd0) && (r < ROW_LIM) && (c >= 5'sd0) && (c < COL_LIM)
                    && (board_i[r[2:0]][c[2:0]] == player_i)) begin
                    cnt = cnt + 3'd1;
                end else begin
                    run = 1'b0;
                end
            end
        end
        count_o = (cnt >= 3'(WIN_LEN)) ? 3'(WIN_LEN) : cnt;
    end
endmodule

// File: rtl/connect4_board.sv
// Connect Four engine: gravity drop into a column, then one-cycle-per-direction win scan.
// Accept-to-accept is 6 cycles; move_valid is ignored (not queued) while move_ready is low.
module connect4_board
    import connect4_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       new_game_i,
    input  logic       move_valid_i,
    input  logic [2:0] move_col_i,
    output logic       move_ready_o,
    output logic       move_reject_o,
    output board_t     grid_o,
    output logic [1:0] current_player_o,
    output logic       game_over_o,
    output logic [1:0] winner_o
);
    state_t     state_q;
    board_t     grid_q;
    logic [2:0] col_q;
    logic [2:0] row_q;
    cell_t      player_q;
    winner_t    winner_q;
    logic [5:0] count_q;
    logic       game_over_q;
    logic       ready_q;
    logic       reject_q;

    logic              col_ok;
    logic              col_full;
    logic [2:0]        col_idx;
    logic [2:0]        tgt_row;
    logic signed [1:0] dr;
    logic signed [1:0] dc;
    logic [2:0]        line_cnt;
    logic              line_win;

    always_comb begin
        col_ok   = (col_q < 3'(COLS));
        col_idx  = col_ok ? col_q : 3'd0;
        col_full = !col_ok || (grid_q[3'd0][col_idx] != EMPTY);
        tgt_row  = 3'd0;
        for (int r = 0; r < ROWS; r++) begin
            if (grid_q[3'(r)][col_idx] == EMPTY) begin
                tgt_row = 3'(r);
            end
        end
    end

    // Only the axis matters: the counter walks both ways from the origin.
    always_comb begin
        case (state_q)
            S_CHK_V:  begin dr = 2'sd1;  dc = 2'sd0; end
            S_CHK_D1: begin dr = 2'sd1;  dc = 2'sd1; end
            S_CHK_D2: begin dr = -2'sd1; dc = 2'sd1; end
            default:  begin dr = 2'sd0;  dc = 2'sd1; end
        endcase
    end

    c4_line_count u_line (
        .board_i  (grid_q),
        .row_i    (row_q),
        .col_i    (col_idx),
        .dr_i     (dr),
        .dc_i     (dc),
        .player_i (player_q),
        .count_o  (line_cnt)
    );

    assign line_win = (line_cnt >= 3'(WIN_LEN));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            grid_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            player_q    <= P1;
            winner_q    <= WIN_NONE;
            count_q     <= '0;
            game_over_q <= 1'b0;
            ready_q     <= 1'b1;
            reject_q    <= 1'b0;
        end else if (new_game_i) begin
            state_q     <= S_IDLE;
            grid_q      <= '0;
            player_q    <= P1;
            winner_q    <= WIN_NONE;
            count_q     <= '0;
            game_over_q <= 1'b0;
            ready_q     <= 1'b1;
            reject_q    <= 1'b0;
        end else begin
            reject_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (move_valid_i && ready_q) begin
                        col_q   <= move_col_i;
                        ready_q <= 1'b0;
                        state_q <= S_PLACE;
                    end
                end
                S_PLACE: begin
                    if (col_full) begin
                        reject_q <= 1'b1;
                        ready_q  <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        grid_q[tgt_row][col_idx] <= player_q;
                        row_q   <= tgt_row;
                        count_q <= count_q + 6'd1;
                        state_q <= S_CHK_H;
                    end
                end
                S_CHK_H, S_CHK_V, S_CHK_D1: begin
                    if (line_win) begin
                        game_over_q <= 1'b1;
                        winner_q    <= (player_q == P1) ? WIN_P1 : WIN_P2;
                        state_q     <= S_END;
                    end else if (state_q == S_CHK_H) begin
                        state_q <= S_CHK_V;
                    end else if (state_q == S_CHK_V) begin
                        state_q <= S_CHK_D1;
                    end else begin
                        state_q <= S_CHK_D2;
                    end
                end
                S_CHK_D2: begin
                    if (line_win) begin
                        game_over_q <= 1'b1;
                        winner_q    <= (player_q == P1) ? WIN_P1 : WIN_P2;
                        state_q     <= S_END;
                    end else if (count_q == 6'(CELLS)) begin
                        game_over_q <= 1'b1;
                        winner_q    <= WIN_DRAW;
                        state_q     <= S_END;
                    end else begin
                        player_q <= (player_q == P1) ? P2 : P1;
                        ready_q  <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                S_END: state_q <= S_END;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign move_ready_o     = ready_q;
    assign move_reject_o    = reject_q;
    assign grid_o           = grid_q;
    assign current_player_o = player_q;
    assign game_over_o      = game_over_q;
    assign winner_o         = winner_q;
endmodule
